kv_csa_cpa: RTL and testbench

Pipelined carry-propagate adder that resolves the redundant sum/carry vector pair produced by the 3:2 carry-save stage of the f16 MAC datapath into a single binary result. It sits directly downstream of the CSA tree and feeds normalization/rounding. It splits the addition into a low-half and a high-half stage with a registered inter-half carry, and it moves data with a valid/ready handshake.

---
 rtl/kv_csa_cpa.sv | 164 ++++++++++++++++
 tb/tb_kv_csa_cpa.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_csa_cpa.sv
`default_nettype none
// ============================================================================
//  Module   : kv_csa_cpa
//  Purpose  : Two-stage pipelined carry-propagate adder. Resolves the
//             redundant sum/carry pair from the 3:2 carry-save stage of the
//             f16 MAC datapath into one binary result for the normalisation
//             and rounding logic downstream.
//
//             Stage 1 adds the low half and registers its carry-out.
//             Stage 2 adds the high half plus that carry.
//             No single cycle holds a full-width carry chain.
//
//  Ports    : core_clk    - clock, rising edge
//             core_reset  - synchronous active-high reset
//             in_valid    - input pair present
//             in_ready    - input pair accepted this cycle
//             in_sum      - CSA sum vector, bit i has weight 2^i
//             in_cout     - CSA carry vector, bit i has weight 2^(i+1)
//             in_cin      - carry-in at weight 2^0
//             out_valid   - result present
//             out_ready   - consumer accepts the result
//             out_res     - resolved result, CSA_WIDTH+1 bits
//             out_zero    - out_res == 0
//
//  Params   : CSA_WIDTH   - vector width; must be even and >= 4
//
//  Revision : 1.0 - initial release
// ============================================================================
module kv_csa_cpa #(
    parameter int CSA_WIDTH = 32
) (
    input  logic                 core_clk,
    input  logic                 core_reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CSA_WIDTH-1:0] in_sum,
    input  logic [CSA_WIDTH-1:0] in_cout,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CSA_WIDTH:0]   out_res,
    output logic                 out_zero
);

    // The low half covers result bits [c_lo_w-1:0]. The high half covers
    // bits [CSA_WIDTH:c_lo_w], which includes the extra top bit.
    localparam int c_lo_w = CSA_WIDTH / 2;
    localparam int c_hi_w = CSA_WIDTH + 1 - c_lo_w;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 r_s1_valid;
    logic [c_lo_w-1:0]    r_s1_lo;
    logic                 r_s1_c;
    logic [c_hi_w-1:0]    r_s1_a;
    logic [c_hi_w-1:0]    r_s1_b;

    logic                 r_out_valid;
    logic [CSA_WIDTH:0]   r_out_res;
    logic                 r_out_zero;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic                 w_in_fire;
    logic                 w_s2_load;
    logic                 w_out_fire;

    // The output register can take a new value when it is empty, or when
    // its current value leaves in this same cycle.
    assign w_out_fire = r_out_valid & out_ready;
    assign w_s2_load  = r_s1_valid & (~r_out_valid | out_ready);

    // Stage 1 can accept when it is empty, or when it drains into stage 2
    // in this same cycle. This path is combinational from out_ready because
    // there is no skid buffer.
    assign in_ready   = ~r_s1_valid | w_s2_load;
    assign w_in_fire  = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Stage 1 datapath: low-half addition
    // ------------------------------------------------------------------
    // Carry vector bit i has weight 2^(i+1). Its low c_lo_w-1 bits
    // therefore sit one position up in the low half. in_cout[c_lo_w-1]
    // has weight 2^c_lo_w, so it belongs to the high half.
    logic [c_lo_w:0]      w_lo_sum;
    logic [c_hi_w-1:0]    w_hi_a;
    logic [c_hi_w-1:0]    w_hi_b;

    assign w_lo_sum = {1'b0, in_sum[c_lo_w-1:0]}
                    + {1'b0, in_cout[c_lo_w-2:0], 1'b0}
                    + {{c_lo_w{1'b0}}, in_cin};

    assign w_hi_a   = {1'b0, in_sum[CSA_WIDTH-1:c_lo_w]};
    assign w_hi_b   = in_cout[CSA_WIDTH-1:c_lo_w-1];

    // ------------------------------------------------------------------
    // Stage 2 datapath: high-half addition with the registered carry
    // ------------------------------------------------------------------
    // Any carry out of the top bit is discarded, so the result wraps
    // modulo 2^(CSA_WIDTH+1).
    logic [c_hi_w-1:0]    w_hi_sum;
    logic [CSA_WIDTH:0]   w_res_next;

    assign w_hi_sum   = r_s1_a + r_s1_b + {{(c_hi_w-1){1'b0}}, r_s1_c};
    assign w_res_next = {w_hi_sum, r_s1_lo};

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_lo    <= '0;
            r_s1_c     <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_lo <= w_lo_sum[c_lo_w-1:0];
                r_s1_c  <= w_lo_sum[c_lo_w];
                r_s1_a  <= w_hi_a;
                r_s1_b  <= w_hi_b;
            end

            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    // out_zero is computed from the value being loaded. This keeps the zero
    // flag and the result consistent and keeps the compare off the output.
    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_zero  <= 1'b1;
        end else begin
            if (w_s2_load) begin
                r_out_res  <= w_res_next;
                r_out_zero <= (w_res_next == '0);
            end

            if (w_s2_load) begin
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_zero  = r_out_zero;

endmodule
`default_nettype wire

// File: tb/tb_kv_csa_cpa.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kv_csa_cpa
//  Purpose  : Self-checking bench for kv_csa_cpa (CSA_WIDTH = 32).
//             - Expected results come from a full-width reference sum.
//             - They are queued when an input fires.
//             - They are popped and compared when an output fires.
//
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kv_csa_cpa;

    localparam int c_w = 32;

    logic           core_clk = 1'b0;
    logic           core_reset;
    logic           in_valid;
    logic           in_ready;
    logic [c_w-1:0] in_sum;
    logic [c_w-1:0] in_cout;
    logic           in_cin;
    logic           out_valid;
    logic           out_ready;
    logic [c_w:0]   out_res;
    logic           out_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [c_w:0] res;
        logic         zero;
    } exp_t;

    exp_t sb_q[$];

    kv_csa_cpa #(.CSA_WIDTH(c_w)) dut (
        .core_clk   (core_clk),
        .core_reset (core_reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_cout    (in_cout),
        .in_cin     (in_cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_zero   (out_zero)
    );

    always #5 core_clk = ~core_clk;

    // Reference: one full-width addition, truncated to c_w+1 bits.
    function automatic exp_t model(input logic [c_w-1:0] s,
                                   input logic [c_w-1:0] c,
                                   input logic           ci);
        exp_t         e;
        logic [c_w:0] full;
        full   = {1'b0, s} + {c, 1'b0} + {{c_w{1'b0}}, ci};
        e.res  = full;
        e.zero = (full == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [c_w:0] obs, input logic [c_w:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at a negedge, after the inputs are driven.
    // - Samples both handshakes just before the next posedge.
    // - Updates the scoreboard.
    // - Returns at the following negedge.
    task automatic tick(output logic fired);
        logic inf;
        logic outf;
        exp_t e;
        #1;
        inf  = in_valid & in_ready;
        outf = out_valid & out_ready;
        if (outf) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed=out_fire res=0x%0h expected=no_output", out_res);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_res", out_res, e.res);
                chk1("sb_zero", out_zero, e.zero);
            end
        end
        if (inf) sb_q.push_back(model(in_sum, in_cout, in_cin));
        fired = inf;
        @(negedge core_clk);
    endtask

    // Presents one item and holds it until it fires (bounded).
    task automatic send(input logic [c_w-1:0] s, input logic [c_w-1:0] c,
                        input logic ci, input logic ordy);
        logic f;
        int   n;
        in_valid  = 1'b1;
        in_sum    = s;
        in_cout   = c;
        in_cin    = ci;
        out_ready = ordy;
        f = 1'b0;
        n = 0;
        while (!f && n < 20) begin
            tick(f);
            n++;
        end
        chk1("send_fired", f, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic ordy);
        logic f;
        in_valid  = 1'b0;
        out_ready = ordy;
        for (int i = 0; i < n; i++) tick(f);
    endtask

    logic [c_w-1:0] bp_s [4];
    logic [c_w-1:0] bp_c [4];
    logic           bp_ci[4];
    exp_t           bp_first;

    initial begin
        logic f;

        core_reset = 1'b1;
        in_valid   = 1'b0;
        in_sum     = '0;
        in_cout    = '0;
        in_cin     = 1'b0;
        out_ready  = 1'b0;
        @(negedge core_clk);
        @(negedge core_clk);
        core_reset = 1'b0;
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk ("rst_out_res",   out_res,   '0);
        chk1("rst_out_zero",  out_zero,  1'b1);
        chk1("rst_in_ready",  in_ready,  1'b1);
        @(negedge core_clk);

        // Cross-half carry and 2-cycle latency.
        in_valid  = 1'b1;
        in_sum    = 32'h0000_FFFF;
        in_cout   = '0;
        in_cin    = 1'b1;
        out_ready = 1'b1;
        tick(f);
        chk1("lat_fire", f, 1'b1);
        in_valid = 1'b0;
        chk1("lat_edge1_valid", out_valid, 1'b0);
        tick(f);
        chk1("lat_edge2_valid", out_valid, 1'b1);
        chk ("xhalf_res",  out_res,  33'h0_0001_0000);
        chk1("xhalf_zero", out_zero, 1'b0);
        idle(1, 1'b1);

        // Full ripple cases.
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        send(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
        idle(2, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        tick(f);
        chk("ripple_res", out_res, 33'h1_0000_0000);
        idle(2, 1'b1);

        // Wrap to zero.
        send(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1);
        tick(f);
        chk ("wrap_res",  out_res,  '0);
        chk1("wrap_zero", out_zero, 1'b1);
        idle(2, 1'b1);

        // Back-pressure: 4 back-to-back inputs, out_ready low for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            bp_s[i]  = $urandom();
            bp_c[i]  = $urandom();
            bp_ci[i] = 1'($urandom_range(0, 1));
        end
        bp_first  = model(bp_s[0], bp_c[0], bp_ci[0]);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sum = bp_s[0]; in_cout = bp_c[0]; in_cin = bp_ci[0];
        tick(f);
        chk1("bp_fire0", f, 1'b1);
        in_sum = bp_s[1]; in_cout = bp_c[1]; in_cin = bp_ci[1];
        tick(f);
        chk1("bp_fire1", f, 1'b1);
        in_sum = bp_s[2]; in_cout = bp_c[2]; in_cin = bp_ci[2];
        #1;
        chk1("bp_in_ready_low", in_ready, 1'b0);
        tick(f);
        chk1("bp_blocked2", f, 1'b0);
        chk ("bp_hold_res_a", out_res, bp_first.res);
        tick(f);
        chk1("bp_blocked3", f, 1'b0);
        chk ("bp_hold_res_b", out_res, bp_first.res);
        chk1("bp_hold_zero",  out_zero, bp_first.zero);
        // Release: 4 results on 4 consecutive cycles.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                in_valid = 1'b1;
                in_sum = bp_s[2]; in_cout = bp_c[2]; in_cin = bp_ci[2];
            end else if (i == 1) begin
                in_valid = 1'b1;
                in_sum = bp_s[3]; in_cout = bp_c[3]; in_cin = bp_ci[3];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk1("bp_no_gap", out_valid, 1'b1);
            tick(f);
            if (i < 2) chk1("bp_late_fire", f, 1'b1);
        end
        in_valid = 1'b0;
        chk("bp_drained", 33'(sb_q.size()), '0);

        // Streaming: random input every cycle with out_ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_sum   = $urandom();
            in_cout  = $urandom();
            in_cin   = 1'($urandom_range(0, 1));
            #1;
            chk1("stream_in_ready", in_ready, 1'b1);
            tick(f);
        end
        idle(3, 1'b1);
        chk("stream_drained", 33'(sb_q.size()), '0);

        // Reset with both stages full.
        send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
        send(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 1'b0);
        #1;
        chk1("mid_full_in_ready", in_ready, 1'b0);
        core_reset = 1'b1;
        @(negedge core_clk);
        core_reset = 1'b0;
        #1;
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk ("mid_rst_out_res",   out_res,   '0);
        chk1("mid_rst_out_zero",  out_zero,  1'b1);
        chk1("mid_rst_in_ready",  in_ready,  1'b1);
        sb_q.delete();
        idle(5, 1'b1);

        // Recovery after reset.
        send(32'h0000_0003, 32'h0000_0002, 1'b1, 1'b1);
        idle(3, 1'b1);
        chk("final_drained", 33'(sb_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
